inst_fetch_responder: RTL

//  Memory-side responder for the Sirius instruction fetch port. It serves rom_ce/rom_addr requests from the core.

---
 rtl/inst_fetch_responder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: synchronous word array with programmable wait
// states in front of the core's rom_ce/rom_addr fetch port, plus a write-only
// load port for filling the array.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | no fetch outstanding; a new request is accepted here
//   S_ACCEPT | request latched; counter holds WAIT_CYCLES
//   S_WAIT   | counting down wait states; rom_ce_i low aborts the fetch
//   S_RESP   | rom_ready_o high for this one cycle; back-to-back accept here
module inst_fetch_responder #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                DEPTH_LOG2  = 10,
   parameter int                WAIT_CYCLES = 1,
   parameter logic [DATA_W-1:0] NOP_WORD    = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rom_ce_i,
   input  logic [ADDR_W-1:0] rom_addr_i,
   output logic [DATA_W-1:0] rom_data_o,
   output logic              rom_ready_o,
   output logic              rom_err_o,
   input  logic              load_we_i,
   input  logic [ADDR_W-1:0] load_addr_i,
   input  logic [DATA_W-1:0] load_data_i,
   output logic              busy_o
);

   localparam int         DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
   logic                    err_q, err_d;
   logic [DATA_W-1:0]       data_q, data_d;
   logic                    ready_q, ready_d;
   logic                    rom_err_q, rom_err_d;

   logic [DATA_W-1:0]       mem_q [DEPTH];

   logic [DEPTH_LOG2-1:0]   fetch_idx;
   logic                    fetch_err;
   logic [DEPTH_LOG2-1:0]   load_idx;
   logic                    load_ok;
   logic                    unused_load_lsb;

   // Address decode for the fetch and load ports.
   always_comb begin
      fetch_idx       = rom_addr_i[DEPTH_LOG2+1:2];
      fetch_err       = (rom_addr_i[1:0] != 2'b00) ||
                        (rom_addr_i[ADDR_W-1:DEPTH_LOG2+2] != '0);
      load_idx        = load_addr_i[DEPTH_LOG2+1:2];
      load_ok         = (load_addr_i[ADDR_W-1:DEPTH_LOG2+2] == '0);
      unused_load_lsb = ^load_addr_i[1:0];
   end

   // Word array: no reset, out-of-range loads dropped. The response read below
   // sees the pre-edge contents, so a same-edge write returns the old word.
   always_ff @(posedge clk) begin
      if (load_we_i && load_ok) begin
         mem_q[load_idx] <= load_data_i;
      end
   end

   // State, counter, latched request and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         data_q    <= NOP_WORD;
         ready_q   <= 1'b0;
         rom_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         data_q    <= data_d;
         ready_q   <= ready_d;
         rom_err_q <= rom_err_d;
      end
   end

   // Next-state logic; ready/err are pulses that default low every cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      err_d     = err_q;
      data_d    = data_q;
      ready_d   = 1'b0;
      rom_err_d = 1'b0;

      unique case (state_q)
         S_IDLE, S_RESP: begin
            if (rom_ce_i) begin
               idx_d   = fetch_idx;
               err_d   = fetch_err;
               cnt_d   = WAIT_LD;
               state_d = S_ACCEPT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCEPT: begin
            if (cnt_q == 4'd0) begin
               state_d   = S_RESP;
               ready_d   = 1'b1;
               rom_err_d = err_q;
               data_d    = err_q ? NOP_WORD : mem_q[idx_q];
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!rom_ce_i) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd1) begin
               state_d   = S_RESP;
               cnt_d     = 4'd0;
               ready_d   = 1'b1;
               rom_err_d = err_q;
               data_d    = err_q ? NOP_WORD : mem_q[idx_q];
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rom_data_o  = data_q;
   assign rom_ready_o = ready_q;
   assign rom_err_o   = rom_err_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule
